// File: rtl/div_writeback_queue.sv
// Divide-result writeback queue: buffers divide-unit results and drains them into
// the register-file write port in cycles the main pipeline leaves it free. Also
// reports RAW hazards on queued destinations and a full flag for divide issue.
module div_writeback_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            done_du,
  input  logic            wen_du,
  input  logic [4:0]      reg_rd_du,
  input  logic [XLEN-1:0] wdata_du,
  input  logic            pipe_wen,
  input  logic [4:0]      query_rs1,
  input  logic [4:0]      query_rs2,
  output logic            rf_wen,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic            full,
  output logic            empty,
  output logic            hazard,
  output logic            overflow_err
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] valid;
  logic [4:0]       ent_rd   [DEPTH];
  logic [XLEN-1:0]  ent_data [DEPTH];

  logic push;
  logic pop;
  logic accept;
  logic hit1;
  logic hit2;

  // Queue control: x0 and non-writing results never enter; a full queue only
  // takes a result when the head drains in the same cycle.
  always_comb begin
    push   = done_du & wen_du & (reg_rd_du != 5'd0);
    pop    = ~empty & ~pipe_wen;
    accept = push & (~full | pop);
  end

  // Status flags come from registered count only, so they never glitch on inputs.
  always_comb begin
    full  = (count == CNT_W'(DEPTH));
    empty = (count == CNT_W'(0));
  end

  // RF write port: queue writes only when the main pipeline is idle.
  always_comb begin
    rf_wen   = pop;
    rf_rd    = 5'd0;
    rf_wdata = '0;
    if (!empty) begin
      rf_rd    = ent_rd[head];
      rf_wdata = ent_data[head];
    end
  end

  // Hazard: a popping entry still counts because decode cannot see the RF write yet.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && (ent_rd[i] == query_rs1)) hit1 = 1'b1;
      if (valid[i] && (ent_rd[i] == query_rs2)) hit2 = 1'b1;
    end
    if (push && (reg_rd_du == query_rs1)) hit1 = 1'b1;
    if (push && (reg_rd_du == query_rs2)) hit2 = 1'b1;
    hazard = ((query_rs1 != 5'd0) & hit1) | ((query_rs2 != 5'd0) & hit2);
  end

  // Pointer, count, valid and sticky overflow state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      valid        <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      // Set after clear so a full push+pop onto the same slot leaves it valid.
      if (accept) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PTR_W'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push && !accept) overflow_err <= 1'b1;
    end
  end

  // Entry payload storage; contents are only observed through valid/empty.
  always_ff @(posedge CLK) begin
    if (accept) begin
      ent_rd[tail]   <= reg_rd_du;
      ent_data[tail] <= wdata_du;
    end
  end

endmodule

// File: tb/tb_div_writeback_queue.sv
// Directed bench for div_writeback_queue: per-cycle vector table plus hand-written
// reset-mid-queue and full-with-push-and-pop sequences.
module tb_div_writeback_queue;

  logic        CLK;
  logic        RST;
  logic        done_du;
  logic        wen_du;
  logic [4:0]  reg_rd_du;
  logic [31:0] wdata_du;
  logic        pipe_wen;
  logic [4:0]  query_rs1;
  logic [4:0]  query_rs2;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        full;
  logic        empty;
  logic        hazard;
  logic        overflow_err;

  int n_tests = 0;
  int n_fail  = 0;

  div_writeback_queue #(.DEPTH(2), .XLEN(32)) dut (
    .CLK(CLK), .RST(RST),
    .done_du(done_du), .wen_du(wen_du), .reg_rd_du(reg_rd_du), .wdata_du(wdata_du),
    .pipe_wen(pipe_wen), .query_rs1(query_rs1), .query_rs2(query_rs2),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .full(full), .empty(empty), .hazard(hazard), .overflow_err(overflow_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        done;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        pipe;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        e_wen;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_full;
    logic        e_empty;
    logic        e_haz;
    logic        e_ovf;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t mk(logic done, logic wen, logic [4:0] rd, logic [31:0] data,
                              logic pipe, logic [4:0] q1, logic [4:0] q2,
                              logic e_wen, logic [4:0] e_rd, logic [31:0] e_data,
                              logic e_full, logic e_empty, logic e_haz, logic e_ovf);
    vec_t v;
    v.done = done; v.wen = wen; v.rd = rd; v.data = data;
    v.pipe = pipe; v.q1 = q1; v.q2 = q2;
    v.e_wen = e_wen; v.e_rd = e_rd; v.e_data = e_data;
    v.e_full = e_full; v.e_empty = e_empty; v.e_haz = e_haz; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Drive inputs just after the falling edge; outputs are sampled mid-cycle.
  task automatic drive(input logic done, input logic wen, input logic [4:0] rd,
                       input logic [31:0] data, input logic pipe,
                       input logic [4:0] q1, input logic [4:0] q2);
    @(negedge CLK);
    done_du = done; wen_du = wen; reg_rd_du = rd; wdata_du = data;
    pipe_wen = pipe; query_rs1 = q1; query_rs2 = q2;
    #1;
  endtask

  initial begin
    // Expected columns: rf_wen rf_rd rf_wdata full empty hazard overflow_err
    // idle after reset
    vecs[0]  = mk(0,0, 0, 32'h0,  0, 0,0,  0, 0,32'h0,  0,1,0,0);
    // single result rd=5 data=7: no bypass, written next cycle, then empty
    vecs[1]  = mk(1,1, 5, 32'h7,  0, 5,0,  0, 0,32'h0,  0,1,1,0);
    vecs[2]  = mk(0,0, 0, 32'h0,  0, 5,0,  1, 5,32'h7,  0,0,1,0);
    vecs[3]  = mk(0,0, 0, 32'h0,  0, 5,0,  0, 0,32'h0,  0,1,0,0);
    // pipe_wen priority held 4 cycles with rd=3 queued
    vecs[4]  = mk(1,1, 3, 32'h33, 1, 3,0,  0, 0,32'h0,  0,1,1,0);
    vecs[5]  = mk(0,0, 0, 32'h0,  1, 3,0,  0, 3,32'h33, 0,0,1,0);
    vecs[6]  = mk(0,0, 0, 32'h0,  1, 3,0,  0, 3,32'h33, 0,0,1,0);
    vecs[7]  = mk(0,0, 0, 32'h0,  1, 3,0,  0, 3,32'h33, 0,0,1,0);
    vecs[8]  = mk(0,0, 0, 32'h0,  0, 3,0,  1, 3,32'h33, 0,0,1,0);
    vecs[9]  = mk(0,0, 0, 32'h0,  0, 3,0,  0, 0,32'h0,  0,1,0,0);
    // fill to full under stall, overflow drop of rd=4, then drain in order
    vecs[10] = mk(1,1, 1, 32'h11, 1, 1,2,  0, 0,32'h0,  0,1,1,0);
    vecs[11] = mk(1,1, 2, 32'h22, 1, 1,2,  0, 1,32'h11, 0,0,1,0);
    vecs[12] = mk(1,1, 4, 32'h44, 1, 4,0,  0, 1,32'h11, 1,0,1,0);
    vecs[13] = mk(0,0, 0, 32'h0,  1, 4,0,  0, 1,32'h11, 1,0,0,1);
    vecs[14] = mk(0,0, 0, 32'h0,  0, 1,2,  1, 1,32'h11, 1,0,1,1);
    vecs[15] = mk(0,0, 0, 32'h0,  0, 1,2,  1, 2,32'h22, 0,0,1,1);
    vecs[16] = mk(0,0, 0, 32'h0,  0, 1,2,  0, 0,32'h0,  0,1,0,1);
    // x0 and wen_du=0 results are discarded
    vecs[17] = mk(1,1, 0, 32'h99, 0, 0,0,  0, 0,32'h0,  0,1,0,1);
    vecs[18] = mk(1,0, 7, 32'h77, 0, 7,0,  0, 0,32'h0,  0,1,0,1);
    vecs[19] = mk(0,0, 0, 32'h0,  0, 7,0,  0, 0,32'h0,  0,1,0,1);

    RST = 1'b1;
    done_du = 0; wen_du = 0; reg_rd_du = 0; wdata_du = 0;
    pipe_wen = 0; query_rs1 = 0; query_rs2 = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].done, vecs[i].wen, vecs[i].rd, vecs[i].data,
            vecs[i].pipe, vecs[i].q1, vecs[i].q2);
      chk($sformatf("v%0d rf_wen", i),       32'(rf_wen),       32'(vecs[i].e_wen));
      chk($sformatf("v%0d rf_rd", i),        32'(rf_rd),        32'(vecs[i].e_rd));
      chk($sformatf("v%0d rf_wdata", i),     rf_wdata,          vecs[i].e_data);
      chk($sformatf("v%0d full", i),         32'(full),         32'(vecs[i].e_full));
      chk($sformatf("v%0d empty", i),        32'(empty),        32'(vecs[i].e_empty));
      chk($sformatf("v%0d hazard", i),       32'(hazard),       32'(vecs[i].e_haz));
      chk($sformatf("v%0d overflow_err", i), 32'(overflow_err), 32'(vecs[i].e_ovf));
    end

    // Reset mid-queue with two entries; overflow_err is still set from the table.
    drive(1,1, 10, 32'hA, 1, 0,0);
    drive(1,1, 11, 32'hB, 1, 0,0);
    drive(0,0, 0, 32'h0, 1, 10,11);
    chk("pre-reset full", 32'(full), 32'd1);
    @(negedge CLK);
    RST = 1'b1;
    pipe_wen = 1'b0;
    #1;
    chk("reset empty",        32'(empty),        32'd1);
    chk("reset full",         32'(full),         32'd0);
    chk("reset rf_wen",       32'(rf_wen),       32'd0);
    chk("reset rf_rd",        32'(rf_rd),        32'd0);
    chk("reset rf_wdata",     rf_wdata,          32'd0);
    chk("reset hazard",       32'(hazard),       32'd0);
    chk("reset overflow_err", 32'(overflow_err), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(0,0, 0, 32'h0, 0, 10,11);
      chk($sformatf("post-reset c%0d rf_wen", c), 32'(rf_wen), 32'd0);
      chk($sformatf("post-reset c%0d empty", c),  32'(empty),  32'd1);
      chk($sformatf("post-reset c%0d hazard", c), 32'(hazard), 32'd0);
    end

    // Full with simultaneous push and pop: rd=9 accepted, no overflow.
    drive(1,1, 12, 32'hC, 1, 0,0);
    drive(1,1, 13, 32'hD, 1, 0,0);
    drive(1,1, 9,  32'h9, 0, 9,0);
    chk("fpp full",     32'(full),   32'd1);
    chk("fpp rf_wen",   32'(rf_wen), 32'd1);
    chk("fpp rf_rd",    32'(rf_rd),  32'd12);
    chk("fpp rf_wdata", rf_wdata,    32'hC);
    chk("fpp hazard",   32'(hazard), 32'd1);
    drive(0,0, 0, 32'h0, 0, 9,0);
    chk("fpp+1 full",         32'(full),         32'd1);
    chk("fpp+1 overflow_err", 32'(overflow_err), 32'd0);
    chk("fpp+1 rf_rd",        32'(rf_rd),        32'd13);
    chk("fpp+1 rf_wdata",     rf_wdata,          32'hD);
    chk("fpp+1 hazard",       32'(hazard),       32'd1);
    drive(0,0, 0, 32'h0, 0, 9,0);
    chk("fpp+2 rf_wen",   32'(rf_wen), 32'd1);
    chk("fpp+2 rf_rd",    32'(rf_rd),  32'd9);
    chk("fpp+2 rf_wdata", rf_wdata,    32'h9);
    chk("fpp+2 full",     32'(full),   32'd0);
    drive(0,0, 0, 32'h0, 0, 9,0);
    chk("fpp+3 empty",        32'(empty),        32'd1);
    chk("fpp+3 hazard",       32'(hazard),       32'd0);
    chk("fpp+3 overflow_err", 32'(overflow_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
